fare_payment_collector: RTL and testbench
=========================================

# fare_payment_collector

Accepts a computed journey fare (the 16-bit total cost from the journey selection fare calculator) and runs the passenger payment transaction against it. It accumulates inserted coins or notes, issues a ticket once the fare is covered, and returns change. It refunds the paid amount on cancel or inactivity timeout. It sits downstream of the fare calculator and drives the ticket printer and coin-return hopper.

## Interface
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT with no accepted coin before automatic refund (>= 2)
- clk  in  1  system clock, rising edge
- rd  in  1  synchronous active-low reset
- fare_valid  in  1  one-cycle strobe: fare is valid
- fare  in  16  fare in currency units (the calculator's total cost)
- coin_valid  in  1  one-cycle strobe: a coin or note is inserted
- coin_denom  in  3  denomination code: 0=1, 1=2, 2=5, 3=10, 4=20, 5=50, 6=100, 7=500
- cancel  in  1  passenger cancel request (level, sampled each cycle)
- out_ready  in  1  hopper ready to take one return coin
- busy  out  1  transaction in progress (state != IDLE)
- paid_total  out  17  credit accumulated in current transaction
- coin_reject  out  1  one-cycle pulse: the coin presented this cycle was not accepted
- ticket_issue  out  1  one-cycle pulse: print ticket
- out_valid  out  1  a return coin is presented
- out_denom  out  3  denomination of presented return coin (same code)
- refunding  out  1  current dispensing is a refund, not change

## Operation
- States: IDLE, COLLECT, ISSUE, CHANGE, REFUND.
- IDLE:
  - fare_valid latches fare.
  - If fare==0, go to ISSUE; otherwise go to COLLECT, clear paid and the timer.
  - coin_valid in IDLE gives coin_reject.
- COLLECT, in priority order:
  - cancel: the same-cycle coin is rejected. Go to REFUND if paid>0, else to IDLE.
  - coin_valid: paid += value and the timer clears. If the new paid >= fare, go to ISSUE.
  - Timer reaches TIMEOUT_CYCLES-1 with no coin that cycle: go to REFUND if paid>0, else to IDLE.
  - Otherwise the timer increments.
- ISSUE (exactly one cycle): ticket_issue=1 and remaining = paid - fare.
  - Go to CHANGE if remaining>0, else to IDLE.
- CHANGE / REFUND:
  - The REFUND entry loads remaining = paid.
  - out_valid=1 and out_denom = the largest denomination <= remaining (greedy).
  - A transfer happens on a cycle with out_valid & out_ready; remaining -= the value of that coin.
  - The transfer that makes remaining 0 moves the state to IDLE.
  - cancel is ignored in CHANGE and REFUND.
- fare_valid and fare are ignored whenever the state is not IDLE.
- coin_valid in any state other than COLLECT, or when the COLLECT cancel rule applies, gives coin_reject.
- Arithmetic:
  - paid is 17 bits. Its maximum is fare-1+500 < 2^17, so it never overflows.
  - remaining is 17 bits. Change is always < 500.
- refunding = (state==REFUND). paid_total holds its value through ISSUE/CHANGE/REFUND and clears on return to IDLE.

## Timing
- Reset values (rd=0 at a clock edge, any state, including mid-dispense):
  - state IDLE; paid, remaining and timer 0.
  - All outputs 0 (out_denom=0).
  - A coin being presented is abandoned, with no further out_valid.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs except out_valid/out_denom → unchanged by out_ready in same cycle.
- fare_valid at edge N: busy=1 from N+1.
- Covering coin at edge N: ticket_issue=1 during cycle N+1. The first change coin is valid at N+2.
- coin_reject is asserted in the cycle after the rejected coin_valid.
- out_valid/out_denom stay stable while out_ready=0 (no drop, no change of denomination).
- Throughput is one return coin per cycle when out_ready is held high.
- Timeout: the REFUND/IDLE transition occurs TIMEOUT_CYCLES edges after the last accepted coin (or after COLLECT entry).

## Test plan
- fare=35; coins 20, 20 → ticket_issue pulse one cycle after the second coin, paid_total=40. Then one return coin denom code 2 (5) and back to IDLE.
- fare=0 strobe → ticket_issue at the next cycle, no out_valid, IDLE after ISSUE, busy high for 1 cycle.
- fare=100; coins 10, 2; then cancel together with coin 50 → coin_reject for the 50, refunding=1. Returns 10 then 2, then IDLE with paid_total=0.
- TIMEOUT_CYCLES=8, fare=30; coin 5, then silence → REFUND 8 edges after the coin, one coin code 2 returned. A second case with no coin at all returns to IDLE silently.
- fare=1; coin 500 → change 499 dispensed as 100×4, 50, 20×2, 5, 2×2. With out_ready toggling, each denomination stays stable until its transfer and the total returned is 499.
- Reset asserted mid-CHANGE, then fare_valid during CHANGE → out_valid drops after the reset edge and all outputs are 0. A fare_valid strobed during CHANGE before the reset is ignored.

Source files
------------

// File: rtl/fare_payment_collector_if.sv
// fare_payment_collector_if: fare, coin and return-coin signals of the payment collector.
interface fare_payment_collector_if;
  logic        fare_valid;
  logic [15:0] fare;
  logic        coin_valid;
  logic [2:0]  coin_denom;
  logic        cancel;
  logic        out_ready;
  logic        busy;
  logic [16:0] paid_total;
  logic        coin_reject;
  logic        ticket_issue;
  logic        out_valid;
  logic [2:0]  out_denom;
  logic        refunding;
  modport master (
    output fare_valid, fare, coin_valid, coin_denom, cancel, out_ready,
    input  busy, paid_total, coin_reject, ticket_issue, out_valid, out_denom, refunding
  );
  modport slave (
    input  fare_valid, fare, coin_valid, coin_denom, cancel, out_ready,
    output busy, paid_total, coin_reject, ticket_issue, out_valid, out_denom, refunding
  );
endinterface

// File: rtl/fare_payment_collector.sv
// fare_payment_collector: collects coins against a fare, issues the ticket, and returns change or refunds greedily.
module fare_payment_collector #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic rd,
  fare_payment_collector_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, CHANGE, REFUND} state_t;
  state_t state, state_n;
  logic [15:0] fare_q, fare_n;
  logic [16:0] paid, paid_n, rem, rem_n, paid_coin, out_val;
  logic [TW-1:0] timer, timer_n;
  logic reject, reject_n, dispensing;
  logic [2:0] greedy;
  function automatic logic [16:0] value(input logic [2:0] d);
    case (d)
      3'd0: value = 17'd1;
      3'd1: value = 17'd2;
      3'd2: value = 17'd5;
      3'd3: value = 17'd10;
      3'd4: value = 17'd20;
      3'd5: value = 17'd50;
      3'd6: value = 17'd100;
      default: value = 17'd500;
    endcase
  endfunction
  always_comb begin
    paid_coin = paid + value(bus.coin_denom);
    greedy = rem >= 17'd500 ? 3'd7 : rem >= 17'd100 ? 3'd6 : rem >= 17'd50 ? 3'd5 :
             rem >= 17'd20 ? 3'd4 : rem >= 17'd10 ? 3'd3 : rem >= 17'd5 ? 3'd2 :
             rem >= 17'd2 ? 3'd1 : 3'd0;
    out_val = value(greedy);
    state_n = state;
    fare_n = fare_q;
    paid_n = paid;
    rem_n = rem;
    timer_n = timer;
    reject_n = bus.coin_valid;
    case (state)
      IDLE: if (bus.fare_valid) begin
        fare_n = bus.fare;
        timer_n = '0;
        state_n = bus.fare == 16'd0 ? ISSUE : COLLECT;
      end
      COLLECT: if (bus.cancel) begin
        rem_n = paid;
        state_n = paid != 17'd0 ? REFUND : IDLE;
      end else if (bus.coin_valid) begin
        reject_n = 1'b0;
        paid_n = paid_coin;
        timer_n = '0;
        if (paid_coin >= {1'b0, fare_q}) state_n = ISSUE;
      end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
        rem_n = paid;
        state_n = paid != 17'd0 ? REFUND : IDLE;
      end else begin
        timer_n = timer + 1'b1;
      end
      ISSUE: begin
        rem_n = paid - {1'b0, fare_q};
        state_n = paid != {1'b0, fare_q} ? CHANGE : IDLE;
      end
      CHANGE, REFUND: if (bus.out_ready) begin
        rem_n = rem - out_val;
        if (rem == out_val) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) paid_n = '0;
  end
  always_ff @(posedge clk) begin
    if (!rd) begin
      state <= IDLE;
      fare_q <= '0;
      paid <= '0;
      rem <= '0;
      timer <= '0;
      reject <= 1'b0;
    end else begin
      state <= state_n;
      fare_q <= fare_n;
      paid <= paid_n;
      rem <= rem_n;
      timer <= timer_n;
      reject <= reject_n;
    end
  end
  assign dispensing = state == CHANGE || state == REFUND;
  assign bus.busy = state != IDLE;
  assign bus.paid_total = paid;
  assign bus.coin_reject = reject;
  assign bus.ticket_issue = state == ISSUE;
  assign bus.out_valid = dispensing;
  assign bus.out_denom = dispensing ? greedy : 3'd0;
  assign bus.refunding = state == REFUND;
endmodule

// File: tb/tb_fare_payment_collector.sv
// tb_fare_payment_collector: directed payment, change, cancel, timeout and reset scenarios.
module tb_fare_payment_collector;
  logic clk, rd;
  int checks, errors, total;
  int unsigned val [8] = '{1, 2, 5, 10, 20, 50, 100, 500};
  int unsigned seq [10] = '{6, 6, 6, 6, 5, 4, 4, 2, 1, 1};
  fare_payment_collector_if bus();
  fare_payment_collector #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rd(rd), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put_fare(input logic [15:0] f);
    bus.fare_valid = 1'b1;
    bus.fare = f;
    step();
    bus.fare_valid = 1'b0;
  endtask
  task automatic put_coin(input logic [2:0] d);
    bus.coin_valid = 1'b1;
    bus.coin_denom = d;
    step();
    bus.coin_valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    checks = 0;
    errors = 0;
    rd = 1'b0;
    bus.fare_valid = 1'b0;
    bus.fare = '0;
    bus.coin_valid = 1'b0;
    bus.coin_denom = '0;
    bus.cancel = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_busy", bus.busy, 0);
    check("rst_paid", bus.paid_total, 0);
    check("rst_outs", {bus.coin_reject, bus.ticket_issue, bus.out_valid, bus.out_denom, bus.refunding}, 0);
    rd = 1'b1;
    put_coin(3'd0);
    check("idle_reject", bus.coin_reject, 1);
    step();
    check("idle_reject_end", bus.coin_reject, 0);
    // fare 35 paid with 20+20, change 5 held until the hopper is ready
    put_fare(16'd35);
    check("t1_busy", bus.busy, 1);
    put_coin(3'd4);
    check("t1_paid20", bus.paid_total, 20);
    check("t1_no_ticket", bus.ticket_issue, 0);
    put_coin(3'd4);
    check("t1_ticket", bus.ticket_issue, 1);
    check("t1_paid40", bus.paid_total, 40);
    check("t1_no_out", bus.out_valid, 0);
    step();
    check("t1_ticket_end", bus.ticket_issue, 0);
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_denom", bus.out_denom, 2);
    check("t1_not_refund", bus.refunding, 0);
    step();
    check("t1_hold_valid", bus.out_valid, 1);
    check("t1_hold_denom", bus.out_denom, 2);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t1_done_valid", bus.out_valid, 0);
    check("t1_done_busy", bus.busy, 0);
    check("t1_done_paid", bus.paid_total, 0);
    put_fare(16'd0);
    check("t2_ticket", bus.ticket_issue, 1);
    check("t2_busy", bus.busy, 1);
    check("t2_no_out", bus.out_valid, 0);
    step();
    check("t2_idle", bus.busy, 0);
    check("t2_ticket_end", bus.ticket_issue, 0);
    check("t2_no_out_after", bus.out_valid, 0);
    // cancel with a simultaneous 50: the 50 is rejected, 12 is refunded as 10 + 2
    bus.out_ready = 1'b1;
    put_fare(16'd100);
    put_coin(3'd3);
    put_coin(3'd1);
    check("t3_paid12", bus.paid_total, 12);
    bus.cancel = 1'b1;
    put_coin(3'd5);
    bus.cancel = 1'b0;
    check("t3_reject", bus.coin_reject, 1);
    check("t3_refunding", bus.refunding, 1);
    check("t3_paid_hold", bus.paid_total, 12);
    check("t3_denom10", {bus.out_valid, bus.out_denom}, {1'b1, 3'd3});
    step();
    check("t3_reject_end", bus.coin_reject, 0);
    check("t3_denom2", {bus.out_valid, bus.out_denom}, {1'b1, 3'd1});
    step();
    check("t3_idle", bus.busy, 0);
    check("t3_paid0", bus.paid_total, 0);
    check("t3_refund_end", bus.refunding, 0);
    bus.out_ready = 1'b0;
    put_fare(16'd30);
    put_coin(3'd2);
    for (int i = 0; i < 7; i++) step();
    check("t4_still_collect", {bus.busy, bus.refunding}, 2'b10);
    step();
    check("t4_refunding", bus.refunding, 1);
    check("t4_denom", {bus.out_valid, bus.out_denom}, {1'b1, 3'd2});
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t4_idle", bus.busy, 0);
    put_fare(16'd30);
    for (int i = 0; i < 7; i++) step();
    check("t4b_still_collect", bus.busy, 1);
    step();
    check("t4b_idle", bus.busy, 0);
    check("t4b_silent", {bus.out_valid, bus.refunding}, 0);
    // 500 against fare 1: change 499 with the hopper alternating busy/ready
    put_fare(16'd1);
    put_coin(3'd7);
    check("t5_ticket", bus.ticket_issue, 1);
    check("t5_paid500", bus.paid_total, 500);
    step();
    total = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_stall_denom", {bus.out_valid, bus.out_denom}, {1'b1, seq[i][2:0]});
      bus.out_ready = 1'b1;
      total += bus.out_valid ? int'(val[bus.out_denom]) : 0;
      step();
      bus.out_ready = 1'b0;
    end
    check("t5_total", total, 499);
    check("t5_idle", {bus.busy, bus.out_valid}, 0);
    // reset during change dispensing, after an ignored fare strobe
    put_fare(16'd1);
    put_coin(3'd7);
    step();
    put_fare(16'd7);
    check("t6_fare_ignored", {bus.out_valid, bus.out_denom}, {1'b1, 3'd6});
    check("t6_paid_kept", bus.paid_total, 500);
    rd = 1'b0;
    step();
    check("t6_rst_outs", {bus.busy, bus.coin_reject, bus.ticket_issue, bus.out_valid, bus.out_denom, bus.refunding}, 0);
    check("t6_rst_paid", bus.paid_total, 0);
    rd = 1'b1;
    step();
    check("t6_no_resume", {bus.busy, bus.out_valid}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
